mdu_seq: RTL and testbench

Multi-cycle multiply/divide sequencer owning the HI/LO register pair for the 5-stage MIPS core. It executes MULT/MULTU/DIV/DIVU iteratively over 32 cycles. The execute stage uses its handshake to hold the pipeline while an operation is in flight. It also serves MTHI/MTLO writes and presents HI/LO for MFHI/MFLO, which are forwarded to decode like any other execute result.

---
 rtl/mdu_seq.sv | 138 +++++++++++++
 tb/tb_mdu_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative 32-bit multiply/divide sequencer owning HI/LO.
// Shift-add multiply and restoring divide, 32 CALC cycles plus one FIX cycle.
module mdu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opb;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;

    logic        op_onehot;
    logic        op_signed;
    logic        op_div;
    logic        sa;
    logic        sb;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        accept;

    assign op_onehot = (req_op != 4'd0) &&
                       ((req_op & (req_op - 4'd1)) == 4'd0);
    assign op_signed = req_op[0] | req_op[2];
    assign op_div    = req_op[2] | req_op[3];
    assign sa        = op_signed & req_src1[31];
    assign sb        = op_signed & req_src2[31];
    assign mag_a     = sa ? -req_src1 : req_src1;
    assign mag_b     = sb ? -req_src2 : req_src2;
    assign accept    = req_valid & req_ready & op_onehot & ~cancel;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIX) & ~cancel;

    // mult: acc = {partial sum, remaining multiplier bits}
    logic [32:0] sum33;
    logic [63:0] mul_next;
    assign sum33    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_next = {sum33, acc[31:1]};

    // div: acc = {remainder, dividend bits shifting into quotient}
    logic [32:0] r33;
    logic [32:0] diff;
    logic [63:0] div_next;
    assign r33      = {acc[63:32], acc[31]};
    assign diff     = r33 - {1'b0, opb};
    assign div_next = diff[32] ? {r33[31:0], acc[30:0], 1'b0}
                               : {diff[31:0], acc[30:0], 1'b1};

    logic [63:0] prod;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [63:0] res;
    assign prod  = (neg_a ^ neg_b) ? -acc : acc;
    assign quo_s = (neg_a ^ neg_b) ? -acc[31:0] : acc[31:0];
    assign rem_s = neg_a ? -acc[63:32] : acc[63:32];

    // Divide by zero leaves the dividend magnitude as remainder, so HI
    // re-signs to the original rs; only LO needs forcing.
    always_comb begin
        res = prod;
        if (is_div) begin
            if (opb == 32'd0) res = {rem_s, 32'hFFFF_FFFF};
            else              res = {rem_s, quo_s};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            opb    <= 32'd0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!cancel) begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                    if (accept) begin
                        state  <= S_CALC;
                        cnt    <= 5'd31;
                        is_div <= op_div;
                        neg_a  <= sa;
                        neg_b  <= sb;
                        acc    <= {32'd0, op_div ? mag_a : mag_b};
                        opb    <= op_div ? mag_b : mag_a;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!cancel) begin
                        hi <= res[63:32];
                        lo <= res[31:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq.
// Directed and random ops checked against an arithmetic reference model.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_DIVU  = 4'b1000;
    localparam int LAT = 32;

    mdu_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        if (op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p = sa * sb;
        end else if (op[1]) begin
            p = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
        end else if (op[2]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end else begin
            p = {a % b, a / b};
        end
        return p;
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_op = 0; req_src1 = 0; req_src2 = 0;
        cancel = 0; hi_we = 0; lo_we = 0; wdata = 0;
    endtask

    // Issue one op from IDLE and wait for done; noise pokes MTHI/MTLO
    // and further requests while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noise,
                          input bit mthi, output logic [31:0] h,
                          output logic [31:0] l, output int lat,
                          output logic bsy0, output logic rdy);
        @(negedge clk);
        req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
        hi_we = mthi; wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        bsy0 = busy;
        lat = 0;
        while (!done && lat < 100) begin
            if (noise) begin
                hi_we = 1; lo_we = 1; wdata = $urandom;
                req_valid = 1; req_op = 4'b1 << $urandom_range(0, 3);
                req_src1 = $urandom; req_src2 = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        idle_inputs();
        @(negedge clk);
        h = hi; l = lo; rdy = req_ready;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        n_cmp++;
        if ({hi, lo, req_ready, busy, done} !== {64'd0, 3'b100}) begin
            n_bad++;
            $display("FAIL reset: hi=%h lo=%h rdy=%b busy=%b done=%b",
                     hi, lo, req_ready, busy, done);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [6] = '{OP_DIVU, OP_DIV, OP_MULT, OP_MULTU,
                                 OP_DIV, OP_DIV};
        logic [31:0] as  [6] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'h1234_5678,
                                 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] ex  [6] = '{{32'd1, 32'd3},
                                 {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                 {32'd0, 32'd1},
                                 {32'hFFFF_FFFE, 32'd1},
                                 {32'h1234_5678, 32'hFFFF_FFFF},
                                 {32'd0, 32'h8000_0000}};
        logic [31:0] h, l;
        int lat;
        logic b0, rdy;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], 0, 0, h, l, lat, b0, rdy);
            n_cmp++;
            if ({h, l} !== ex[i]) begin
                n_bad++;
                $display("FAIL directed%0d: hi=%h lo=%h want %h", i, h, l,
                         ex[i]);
            end
            n_cmp++;
            if ({lat, b0, rdy} !== {LAT, 2'b11}) begin
                n_bad++;
                $display("FAIL directed%0d timing: lat=%0d busy=%b rdy=%b want %0d 1 1",
                         i, lat, b0, rdy, LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [4] = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'd1};
        logic [31:0] a, b, h, l;
        logic [3:0] op;
        logic [63:0] ex;
        int lat;
        logic b0, rdy;
        bit nz;
        for (int i = 0; i < 24; i++) begin
            op = 4'b1 << $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)]
                                            : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)]
                                            : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            nz = ($urandom_range(0, 1) == 1);
            ex = model(op, a, b);
            run_op(op, a, b, nz, 0, h, l, lat, b0, rdy);
            n_cmp++;
            if ({h, l} !== ex || lat != LAT) begin
                n_bad++;
                $display("FAIL random%0d op=%b a=%h b=%h: hi=%h lo=%h lat=%0d want %h lat=%0d",
                         i, op, a, b, h, l, lat, ex, LAT);
            end
        end
    endtask

    task automatic test_cancel();
        logic [31:0] h, l;
        logic [63:0] ex;
        int lat, seen;
        logic b0, rdy;
        @(negedge clk);
        lo_we = 1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        idle_inputs();
        req_valid = 1; req_op = OP_DIVU; req_src1 = 100; req_src2 = 3;
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        cancel = 1;
        @(negedge clk);
        cancel = 0;
        n_cmp++;
        if ({busy, req_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL cancel state: busy=%b rdy=%b want 0 1", busy,
                     req_ready);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_cmp++;
        if (seen != 0 || lo !== 32'hA5A5_A5A5) begin
            n_bad++;
            $display("FAIL cancel result: done_pulses=%0d lo=%h want 0 a5a5a5a5",
                     seen, lo);
        end
        ex = model(OP_DIVU, 100, 3);
        run_op(OP_DIVU, 100, 3, 0, 0, h, l, lat, b0, rdy);
        n_cmp++;
        if ({h, l} !== ex || ex !== {32'd1, 32'd33}) begin
            n_bad++;
            $display("FAIL cancel rerun: hi=%h lo=%h want 1 33", h, l);
        end
    endtask

    task automatic test_invalid_op();
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        @(negedge clk);
        req_valid = 1; req_op = 4'b0000; req_src1 = 5; req_src2 = 6;
        @(negedge clk);
        req_op = 4'b0011;
        @(negedge clk);
        req_op = OP_MULTU; cancel = 1;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if ({busy, req_ready, hi, lo} !== {2'b01, h0, l0}) begin
            n_bad++;
            $display("FAIL invalid_op: busy=%b rdy=%b hi=%h lo=%h want 0 1 %h %h",
                     busy, req_ready, hi, lo, h0, l0);
        end
    endtask

    task automatic test_mthi_accept();
        logic [31:0] h, l;
        int lat;
        logic b0, rdy;
        run_op(OP_MULTU, 3, 4, 0, 1, h, l, lat, b0, rdy);
        n_cmp++;
        if ({h, l} !== {32'd0, 32'd12}) begin
            n_bad++;
            $display("FAIL mthi_accept: hi=%h lo=%h want 0 c", h, l);
        end
        @(negedge clk);
        hi_we = 1; lo_we = 1; wdata = 32'h1357_9BDF;
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if ({hi, lo} !== {2{32'h1357_9BDF}}) begin
            n_bad++;
            $display("FAIL mthi_idle: hi=%h lo=%h want 13579bdf", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        req_valid = 1; req_op = OP_MULT; req_src1 = 77; req_src2 = 99;
        @(negedge clk);
        idle_inputs();
        repeat (15) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        seen = 0;
        n_cmp++;
        if ({hi, lo, busy, req_ready} !== {64'd0, 2'b01}) begin
            n_bad++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b rdy=%b", hi, lo,
                     busy, req_ready);
        end
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_cmp++;
        if (seen != 0 || {hi, lo} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_mid done: pulses=%0d hi=%h lo=%h want 0",
                     seen, hi, lo);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_directed();
        test_cancel();
        test_invalid_op();
        test_mthi_accept();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
